// File: rtl/defines.sv
// Shared constants and state encoding for the fetch-stage next-PC generator.
// Holds the default address width, the default reset vector and the FSM states.
// Pure declarations; no logic.
package defines;

  localparam int          DATA_WIDTH   = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_BOOT,
    PC_RUN,
    PC_HOLD
  } pc_state_e;

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority redirect selector: index 0 wins, target is word-aligned on the way out.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the selected target is consumed.
module redirect_arb #(
  parameter int DATA_WIDTH   = defines::DATA_WIDTH,
  parameter int NUM_REDIRECT = 2,
  parameter bit ALIGN_CHECK  = 1'b1
) (
  input  logic [NUM_REDIRECT-1:0]                 valid_i,
  input  logic [NUM_REDIRECT-1:0][DATA_WIDTH-1:0] addr_i,
  output logic                                    any_valid_o,
  output logic [DATA_WIDTH-1:0]                   sel_addr_o,
  output logic                                    sel_mis_o
);

  logic [DATA_WIDTH-1:0] raw_addr;

  // Walk from the lowest priority upward so the lowest asserted index is the last write.
  always_comb begin
    raw_addr = '0;
    for (int i = NUM_REDIRECT - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        raw_addr = addr_i[i];
      end
    end
  end

  assign any_valid_o = |valid_i;
  // The PC can only hold word addresses, so the low two bits are dropped here and reported.
  assign sel_addr_o  = {raw_addr[DATA_WIDTH-1:2], 2'b00};
  assign sel_mis_o   = ALIGN_CHECK && any_valid_o && (raw_addr[1:0] != 2'b00);

endmodule

// File: rtl/pc_gen.sv
// Registered next-PC generator: boot cycle, sequential +4 fetch, prioritised redirects.
// Latency: redirect lands on pc_o one cycle later; a redirect seen while waiting lands the cycle after fire.
// Backpressure: pc_o is frozen while fetch_valid_o && !fetch_ready_i; redirects arriving then are buffered.
module pc_gen #(
  parameter int                   DATA_WIDTH   = defines::DATA_WIDTH,
  parameter int                   NUM_REDIRECT = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(defines::RESET_VECTOR),
  parameter bit                   ALIGN_CHECK  = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REDIRECT-1:0]                 redirect_valid_i,
  input  logic [NUM_REDIRECT-1:0][DATA_WIDTH-1:0] redirect_addr_i,
  input  logic                                    stall_i,
  input  logic                                    fetch_ready_i,
  output logic [DATA_WIDTH-1:0]                   pc_o,
  output logic [DATA_WIDTH-1:0]                   pc_plus4_o,
  output logic                                    fetch_valid_o,
  output logic                                    misalign_o,
  output logic                                    redirect_pending_o
);

  import defines::*;

  pc_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  pend_mis_q, pend_mis_d;
  logic                  mis_q, mis_d;
  logic                  wait_q;

  logic                  any_valid;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic                  sel_mis;
  logic                  waiting;
  logic                  fire;

  redirect_arb #(
    .DATA_WIDTH  (DATA_WIDTH),
    .NUM_REDIRECT(NUM_REDIRECT),
    .ALIGN_CHECK (ALIGN_CHECK)
  ) u_arb (
    .valid_i    (redirect_valid_i),
    .addr_i     (redirect_addr_i),
    .any_valid_o(any_valid),
    .sel_addr_o (sel_addr),
    .sel_mis_o  (sel_mis)
  );

  // A stall only suppresses new requests; one already outstanding stays asserted until accepted.
  assign fetch_valid_o = (state_q != PC_BOOT) && (!stall_i || wait_q);
  assign waiting       = fetch_valid_o && !fetch_ready_i;
  assign fire          = fetch_valid_o && fetch_ready_i;

  // Next-state selection: waiting beats redirect beats buffered redirect beats sequential advance.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_addr_d = pend_addr_q;
    pend_mis_d  = pend_mis_q;
    mis_d       = 1'b0;
    case (state_q)
      PC_BOOT: begin
        state_d = PC_RUN;
      end
      default: begin
        if (waiting) begin
          // pc_o must stay put for memory; remember only the newest redirect.
          if (any_valid) begin
            pend_addr_d = sel_addr;
            pend_mis_d  = sel_mis;
            state_d     = PC_HOLD;
          end
        end else if (any_valid) begin
          // A live redirect supersedes anything buffered.
          pc_d    = sel_addr;
          mis_d   = sel_mis;
          state_d = PC_RUN;
        end else if (state_q == PC_HOLD) begin
          pc_d    = pend_addr_q;
          mis_d   = pend_mis_q;
          state_d = PC_RUN;
        end else if (fire) begin
          pc_d = pc_q + DATA_WIDTH'(4);
        end
      end
    endcase
  end

  // State, PC, pending buffer and handshake history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= PC_BOOT;
      pc_q        <= RESET_VECTOR;
      pend_addr_q <= '0;
      pend_mis_q  <= 1'b0;
      mis_q       <= 1'b0;
      wait_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_addr_q <= pend_addr_d;
      pend_mis_q  <= pend_mis_d;
      mis_q       <= mis_d;
      wait_q      <= waiting;
    end
  end

  assign pc_o               = pc_q;
  assign pc_plus4_o         = pc_q + DATA_WIDTH'(4);
  assign misalign_o         = mis_q;
  assign redirect_pending_o = (state_q == PC_HOLD);

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       rv_i;
  logic [1:0][31:0] ra_i;
  logic             stall;
  logic             ready;
  logic [31:0]      pc, pc4;
  logic             fv, mis, pend;

  int checks = 0;
  int errors = 0;

  pc_gen #(
    .DATA_WIDTH  (32),
    .NUM_REDIRECT(2),
    .RESET_VECTOR(RV),
    .ALIGN_CHECK (1'b1)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .redirect_valid_i  (rv_i),
    .redirect_addr_i   (ra_i),
    .stall_i           (stall),
    .fetch_ready_i     (ready),
    .pc_o              (pc),
    .pc_plus4_o        (pc4),
    .fetch_valid_o     (fv),
    .misalign_o        (mis),
    .redirect_pending_o(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: fetch sequencing described with plain flags and arithmetic.
  bit          m_booting = 1'b1;   // first cycle after reset, no request yet
  bit          m_buffered = 1'b0;  // a redirect is parked until the outstanding fetch goes
  logic [31:0] m_pc = RV;
  logic [31:0] m_buf_pc = '0;
  bit          m_buf_mis = 1'b0;
  bit          m_outstanding = 1'b0; // request was offered and refused last cycle
  bit          m_mis = 1'b0;

  always @(negedge clk) begin
    bit          exp_fv, refused, taken, want, tgt_mis;
    logic [31:0] tgt_raw, tgt;
    if (rst) begin
      chk("rst_pc", pc, RV);
      chk("rst_pc4", pc4, RV + 32'd4);
      chk("rst_fv", 32'(fv), 32'd0);
      chk("rst_mis", 32'(mis), 32'd0);
      chk("rst_pend", 32'(pend), 32'd0);
      m_booting = 1'b1; m_buffered = 1'b0; m_pc = RV;
      m_outstanding = 1'b0; m_mis = 1'b0;
    end else begin
      exp_fv = !m_booting && (!stall || m_outstanding);
      chk("pc", pc, m_pc);
      chk("pc4", pc4, m_pc + 32'd4);
      chk("fv", 32'(fv), 32'(exp_fv));
      chk("mis", 32'(mis), 32'(m_mis));
      chk("pend", 32'(pend), 32'(m_buffered));
      want    = rv_i != 2'b00;
      tgt_raw = rv_i[0] ? ra_i[0] : ra_i[1];
      tgt     = tgt_raw & 32'hFFFF_FFFC;
      tgt_mis = want && (tgt_raw[1:0] != 2'b00);
      refused = exp_fv && !ready;
      taken   = exp_fv && ready;
      m_mis   = 1'b0;
      if (m_booting) begin
        m_booting = 1'b0;
      end else if (refused) begin
        if (want) begin
          m_buffered = 1'b1; m_buf_pc = tgt; m_buf_mis = tgt_mis;
        end
      end else if (want) begin
        m_pc = tgt; m_mis = tgt_mis; m_buffered = 1'b0;
      end else if (m_buffered) begin
        m_pc = m_buf_pc; m_mis = m_buf_mis; m_buffered = 1'b0;
      end else if (taken) begin
        m_pc = m_pc + 32'd4;
      end
      m_outstanding = refused;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir0(input logic [31:0] a);
    rv_i = 2'b01; ra_i[0] = a;
  endtask

  initial begin
    rst = 1'b1; rv_i = '0; ra_i = '0; stall = 1'b0; ready = 1'b1;
    tick(); tick();
    // Boot sequence with ready held high.
    rst = 1'b0;
    @(negedge clk); chk("boot_fv", 32'(fv), 32'd0); chk("boot_pc", pc, 32'h100);
    tick(); @(negedge clk); chk("seq0", pc, 32'h100); chk("seq0_fv", 32'(fv), 32'd1);
    tick(); @(negedge clk); chk("seq1", pc, 32'h104);
    tick(); @(negedge clk); chk("seq2", pc, 32'h108);
    // Both sources request: index 0 wins.
    tick(); rv_i = 2'b11; ra_i[0] = 32'h400; ra_i[1] = 32'h800;
    tick(); rv_i = 2'b00; @(negedge clk); chk("prio", pc, 32'h400);
    // Redirect arriving while a fetch is refused gets buffered.
    tick(); redir0(32'h200);
    tick(); rv_i = 2'b00; ready = 1'b0; @(negedge clk); chk("hold_pc", pc, 32'h200);
    tick(); redir0(32'h600);
    tick(); rv_i = 2'b00; ready = 1'b1; @(negedge clk);
    chk("buf_pc", pc, 32'h200); chk("buf_pend", 32'(pend), 32'd1); chk("buf_fv", 32'(fv), 32'd1);
    tick(); @(negedge clk); chk("buf_apply", pc, 32'h600); chk("buf_clear", 32'(pend), 32'd0);
    // Stall with nothing outstanding drops the request and holds the PC.
    tick(); stall = 1'b1; @(negedge clk); chk("stall_fv", 32'(fv), 32'd0); chk("stall_pc", pc, 32'h604);
    tick(); @(negedge clk); chk("stall_pc2", pc, 32'h604);
    // Stall while refused keeps the request alive until accepted.
    tick(); stall = 1'b0; ready = 1'b0;
    tick(); stall = 1'b1; @(negedge clk); chk("swait_fv", 32'(fv), 32'd1); chk("swait_pc", pc, 32'h604);
    tick(); ready = 1'b1; @(negedge clk); chk("swait_fire", 32'(fv), 32'd1);
    tick(); @(negedge clk); chk("swait_after", 32'(fv), 32'd0); chk("swait_pc2", pc, 32'h608);
    stall = 1'b0;
    // Misaligned target: truncated, flagged for one cycle.
    tick(); redir0(32'h302);
    tick(); rv_i = 2'b00; @(negedge clk); chk("mis_pc", pc, 32'h300); chk("mis_on", 32'(mis), 32'd1);
    tick(); @(negedge clk); chk("mis_off", 32'(mis), 32'd0); chk("mis_next", pc, 32'h304);
    // Wraparound at the top of the address space.
    tick(); redir0(32'hFFFF_FFFC);
    tick(); rv_i = 2'b00; @(negedge clk); chk("wrap_top", pc, 32'hFFFF_FFFC); chk("wrap_pc4", pc4, 32'h0);
    tick(); @(negedge clk); chk("wrap", pc, 32'h0);
    // Reset while a redirect is buffered.
    tick(); ready = 1'b0; redir0(32'h700);
    tick(); rv_i = 2'b00; @(negedge clk); chk("pre_rst_pend", 32'(pend), 32'd1);
    tick(); rst = 1'b1; #1;
    chk("rst_hold_pc", pc, RV); chk("rst_hold_pend", 32'(pend), 32'd0); chk("rst_hold_fv", 32'(fv), 32'd0);
    tick(); rst = 1'b0; ready = 1'b1;
    tick(); @(negedge clk); chk("post_rst_pc", pc, RV); chk("post_rst_pend", 32'(pend), 32'd0);
    // Randomised traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      tick();
      rst   = ($urandom_range(0, 299) == 0);
      stall = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      rv_i[0] = ($urandom_range(0, 7) == 0);
      rv_i[1] = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < 2; k++) begin
        case ($urandom_range(0, 2))
          0:       ra_i[k] = $urandom;
          1:       ra_i[k] = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
          default: ra_i[k] = 32'($urandom_range(0, 255)) << 2;
        endcase
      end
    end
    tick(); rst = 1'b0; rv_i = '0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
